// File: rtl/storage_cmp_pkg.sv
// Shared types and defaults for the storage-element compare monitor.
// Supplies the FSM state encoding and default sizing for the monitor and its interface.
package storage_cmp_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_WINDOW = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/storage_compare_monitor_if.sv
// Control, observed-signal and result bundle between the monitor and its driver.
interface storage_compare_monitor_if #(
  parameter int CNT_W = storage_cmp_pkg::DEF_CNT_W
);

  logic             start;
  logic             d;
  logic             qa;
  logic             qb;
  logic             qc;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_qa;
  logic [CNT_W-1:0] cnt_qb;
  logic [CNT_W-1:0] cnt_qc;
  logic [CNT_W-1:0] err_qb;

  modport master (
    output start, d, qa, qb, qc,
    input  busy, done, cnt_d, cnt_qa, cnt_qb, cnt_qc, err_qb
  );

  modport slave (
    input  start, d, qa, qb, qc,
    output busy, done, cnt_d, cnt_qa, cnt_qb, cnt_qc, err_qb
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/storage_compare_monitor.sv
// Counts toggles on d/qa/qb/qc and qb capture errors over a fixed window of clk edges.
// busy/done lag the state register by one edge so results are settled when done rises.
module storage_compare_monitor
  import storage_cmp_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic                      clk,
  input  logic                      reset,
  storage_compare_monitor_if.slave  bus
);

  // state | meaning
  // IDLE  | waiting for start, counters hold last clear
  // ARM   | one cycle: capture prev registers, load window timer
  // RUN   | counting edges until the window timer reaches zero
  // DONE  | results frozen, start re-arms
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ARM  = ARM;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  logic [1:0]       r_state;
  logic [WIN_W-1:0] r_win;
  logic             r_prev_d;
  logic             r_prev_qa;
  logic             r_prev_qb;
  logic             r_prev_qc;
  logic             r_busy;
  logic             r_done;

  logic w_start_ok;
  logic w_run;

  assign w_start_ok = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_run      = (r_state == S_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_win     <= '0;
      r_prev_d  <= 1'b0;
      r_prev_qa <= 1'b0;
      r_prev_qb <= 1'b0;
      r_prev_qc <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy <= (r_state == S_ARM) || w_run;
      r_done <= (r_state == S_DONE) && !bus.start;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) r_state <= S_ARM;
        end
        S_ARM: begin
          r_prev_d  <= bus.d;
          r_prev_qa <= bus.qa;
          r_prev_qb <= bus.qb;
          r_prev_qc <= bus.qc;
          r_win     <= WIN_W'(WINDOW - 1);
          r_state   <= S_RUN;
        end
        default: begin
          r_prev_d  <= bus.d;
          r_prev_qa <= bus.qa;
          r_prev_qb <= bus.qb;
          r_prev_qc <= bus.qc;
          if (r_win == '0) begin
            r_state <= S_DONE;
          end else begin
            r_win <= r_win - 1'b1;
          end
        end
      endcase
    end
  end

  // err_qb compares qb against the d that the FF should have captured one edge earlier
  sat_counter #(.CNT_W(CNT_W)) u_cnt_d (
    .clk(clk), .reset(reset), .i_clear(w_start_ok),
    .i_inc(w_run && (bus.d != r_prev_d)), .o_cnt(bus.cnt_d)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_qa (
    .clk(clk), .reset(reset), .i_clear(w_start_ok),
    .i_inc(w_run && (bus.qa != r_prev_qa)), .o_cnt(bus.cnt_qa)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_qb (
    .clk(clk), .reset(reset), .i_clear(w_start_ok),
    .i_inc(w_run && (bus.qb != r_prev_qb)), .o_cnt(bus.cnt_qb)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_qc (
    .clk(clk), .reset(reset), .i_clear(w_start_ok),
    .i_inc(w_run && (bus.qc != r_prev_qc)), .o_cnt(bus.cnt_qc)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_qb (
    .clk(clk), .reset(reset), .i_clear(w_start_ok),
    .i_inc(w_run && (bus.qb != r_prev_d)), .o_cnt(bus.err_qb)
  );

  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_storage_compare_monitor.sv
// Directed bench: a main monitor (WINDOW=8) plus a narrow-counter instance for saturation.
module tb_storage_compare_monitor;

  localparam int W   = 8;
  localparam int W_S = 20;

  localparam int P_C0  = 0;
  localparam int P_C1  = 1;
  localparam int P_T1  = 2;
  localparam int P_T2  = 3;
  localparam int P_T4  = 4;
  localparam int P_DLY = 5;

  typedef struct {
    int dp; int ap; int bp; int cp;
    int e_d; int e_qa; int e_qb; int e_qc; int e_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic d = 1'b0, qa = 1'b0, qb = 1'b0, qc = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[6];

  always #5 clk = ~clk;

  storage_compare_monitor_if #(.CNT_W(16)) bus_a ();
  storage_compare_monitor_if #(.CNT_W(3))  bus_b ();

  assign bus_a.start = start;
  assign bus_a.d  = d;
  assign bus_a.qa = qa;
  assign bus_a.qb = qb;
  assign bus_a.qc = qc;
  assign bus_b.start = start;
  assign bus_b.d  = d;
  assign bus_b.qa = qa;
  assign bus_b.qb = qb;
  assign bus_b.qc = qc;

  storage_compare_monitor #(.CNT_W(16), .WINDOW(W)) u_dut (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  storage_compare_monitor #(.CNT_W(3), .WINDOW(W_S)) u_sat (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  function automatic logic pbase(int p, int i);
    logic [31:0] u;
    u = i;
    case (p)
      P_C1:    return 1'b1;
      P_T1:    return u[0];
      P_T2:    return u[1];
      P_T4:    return u[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic pat(int p, int i, int dp);
    if (p == P_DLY) return pbase(dp, i - 1);
    return pbase(p, i);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Values for step i are presented before edge i; edge 0 is the one that samples start.
  task automatic drive(vec_t v, int i, logic st);
    d     = pbase(v.dp, i);
    qa    = pat(v.ap, i, v.dp);
    qb    = pat(v.bp, i, v.dp);
    qc    = pat(v.cp, i, v.dp);
    start = st;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(vec_t v, string tag);
    chk({tag, " cnt_d"},  int'(bus_a.cnt_d),  v.e_d);
    chk({tag, " cnt_qa"}, int'(bus_a.cnt_qa), v.e_qa);
    chk({tag, " cnt_qb"}, int'(bus_a.cnt_qb), v.e_qb);
    chk({tag, " cnt_qc"}, int'(bus_a.cnt_qc), v.e_qc);
    chk({tag, " err_qb"}, int'(bus_a.err_qb), v.e_err);
  endtask

  task automatic measure(vec_t v, string tag, int hold_start, int pulse_at);
    for (int i = 0; i <= W + 1; i++) begin
      drive(v, i, (i < hold_start) || (i == pulse_at));
      if (i == 0) begin
        chk({tag, " busy after start edge"}, int'(bus_a.busy), 0);
        chk({tag, " done after start edge"}, int'(bus_a.done), 0);
        chk({tag, " cnt_d cleared"},         int'(bus_a.cnt_d), 0);
        chk({tag, " err_qb cleared"},        int'(bus_a.err_qb), 0);
      end
      if (i == 1) chk({tag, " busy in arm"}, int'(bus_a.busy), 1);
    end
    chk({tag, " done before window end"}, int'(bus_a.done), 0);
    chk({tag, " busy at last count"},     int'(bus_a.busy), 1);
    drive(v, W + 2, 1'b0);
    chk({tag, " done at N+2+W"}, int'(bus_a.done), 1);
    chk({tag, " busy at N+2+W"}, int'(bus_a.busy), 0);
    chk_counts(v, tag);
    drive(v, W + 3, 1'b0);
    chk({tag, " done held"}, int'(bus_a.done), 1);
    chk_counts(v, {tag, " held"});
  endtask

  initial begin
    vec_t vs;
    vecs[0] = '{P_T1, P_T2, P_DLY, P_T4, 8, 4, 8, 2, 0};
    vecs[1] = '{P_T1, P_C1, P_C0,  P_C0, 8, 0, 0, 0, 4};
    vecs[2] = '{P_T2, P_DLY, P_DLY, P_T1, 4, 4, 4, 8, 0};
    vecs[3] = '{P_T4, P_T1, P_C1,  P_T2, 2, 8, 0, 4, 4};
    vecs[4] = '{P_C0, P_C0, P_C0,  P_C0, 0, 0, 0, 0, 0};
    vecs[5] = '{P_C1, P_C0, P_C0,  P_C1, 0, 0, 0, 0, 8};

    // reset held two cycles, then idle with start low
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle busy", int'(bus_a.busy), 0);
    chk("idle done", int'(bus_a.done), 0);
    chk("idle cnt_d", int'(bus_a.cnt_d), 0);
    chk("idle err_qb", int'(bus_a.err_qb), 0);
    chk("idle sat cnt_d", int'(bus_b.cnt_d), 0);

    // saturation on the 3-bit instance: 20 toggles on d, 10 capture errors
    vs = '{P_T1, P_C0, P_C0, P_C0, 0, 0, 0, 0, 0};
    for (int i = 0; i <= W_S + 1; i++) begin
      drive(vs, i, i == 0);
      if (i == 5) begin
        chk("sat cnt_d mid", int'(bus_b.cnt_d), 4);
        chk("sat err_qb mid", int'(bus_b.err_qb), 2);
      end
    end
    chk("sat done early", int'(bus_b.done), 0);
    drive(vs, W_S + 2, 1'b0);
    chk("sat done", int'(bus_b.done), 1);
    chk("sat cnt_d", int'(bus_b.cnt_d), 7);
    chk("sat err_qb", int'(bus_b.err_qb), 7);
    chk("sat cnt_qb", int'(bus_b.cnt_qb), 0);

    // table vectors; each start after the first re-triggers from DONE
    for (int k = 0; k < 6; k++) begin
      measure(vecs[k], $sformatf("vec%0d", k), (k == 0) ? 3 : 1, (k == 2) ? 5 : -1);
    end

    // abort mid-run by reset, then a fresh measurement
    for (int i = 0; i <= 4; i++) drive(vecs[1], i, i == 0);
    chk("abort pre cnt_d", int'(bus_a.cnt_d), 3);
    chk("abort pre busy", int'(bus_a.busy), 1);
    reset = 1'b1;
    drive(vecs[1], 5, 1'b0);
    reset = 1'b0;
    chk("abort busy", int'(bus_a.busy), 0);
    chk("abort done", int'(bus_a.done), 0);
    chk("abort cnt_d", int'(bus_a.cnt_d), 0);
    chk("abort err_qb", int'(bus_a.err_qb), 0);
    measure(vecs[1], "restart", 1, 4);

    // reset and start together: reset wins, no measurement begins
    reset = 1'b1;
    drive(vecs[0], 0, 1'b1);
    reset = 1'b0;
    drive(vecs[0], 1, 1'b0);
    chk("reset+start busy", int'(bus_a.busy), 0);
    drive(vecs[0], 2, 1'b0);
    chk("reset+start still idle", int'(bus_a.busy), 0);
    chk("reset+start done", int'(bus_a.done), 0);

    measure(vecs[2], "after idle", 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
